// File: rtl/sdram_pkg.sv
// Shared SDRAM bus definitions: command encodings, error codes, mode-register fields.
package sdram_pkg;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}; any cs_n=1 value is DESELECT
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_BURST_TERM = 4'b0110;

    // Violation codes reported on err_code
    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_UNPROG   = 4'd1;
    localparam logic [3:0] ERR_IDLE     = 4'd2;
    localparam logic [3:0] ERR_ACT_OPEN = 4'd3;
    localparam logic [3:0] ERR_TRCD     = 4'd4;
    localparam logic [3:0] ERR_TRP      = 4'd5;
    localparam logic [3:0] ERR_TRC      = 4'd6;
    localparam logic [3:0] ERR_MODE     = 4'd7;
    localparam logic [3:0] ERR_BUS      = 4'd8;

    // Mode-register field positions on sdram_addr
    localparam int unsigned MODE_BL_LSB = 0;
    localparam int unsigned MODE_BL_MSB = 2;
    localparam int unsigned MODE_CL_LSB = 4;
    localparam int unsigned MODE_CL_MSB = 6;

    // Address bit carrying the auto-precharge / all-banks flag
    localparam int unsigned A10 = 10;

    // Bank states
    localparam logic [0:0] BANK_IDLE   = 1'b0;
    localparam logic [0:0] BANK_ACTIVE = 1'b1;

    // Width of the saturating timing counters
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sdram_bank_tracker.sv
// One SDRAM bank: open/idle state, open row, and timing counters that flag tRCD/tRP/tRC.
module sdram_bank_tracker
    import sdram_pkg::*;
#(
    parameter int ROW_W = 2,
    parameter int T_RCD = 2,
    parameter int T_RP  = 2,
    parameter int T_RC  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             do_active,
    input  logic             do_precharge,
    input  logic             do_refresh,
    input  logic [ROW_W-1:0] row_in,
    output logic             active,
    output logic [ROW_W-1:0] row,
    output logic             viol_rcd,
    output logic             viol_rp,
    output logic             viol_rc
);

    logic [0:0]       state;
    // Edges since the last ACTIVE or PRECHARGE; loaded with 1 so the value equals the edge distance
    logic [CNT_W-1:0] cnt;
    // Edges since the last ACTIVE or REFRESH
    logic [CNT_W-1:0] rc_cnt;

    // State, row and counter updates; counters start saturated so reset causes no false violations
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= BANK_IDLE;
            row    <= '0;
            cnt    <= '1;
            rc_cnt <= '1;
        end else if (en) begin
            if (do_active || do_precharge)
                cnt <= CNT_W'(1);
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);

            if (do_active || do_refresh)
                rc_cnt <= CNT_W'(1);
            else if (rc_cnt != '1)
                rc_cnt <= rc_cnt + CNT_W'(1);

            if (do_active) begin
                state <= BANK_ACTIVE;
                row   <= row_in;
            end else if (do_precharge) begin
                state <= BANK_IDLE;
            end
        end
    end

    // Timing checks against the command being sampled at the coming edge
    always_comb begin
        active   = (state == BANK_ACTIVE);
        viol_rcd = active && (cnt < CNT_W'(T_RCD));
        viol_rp  = !active && (cnt < CNT_W'(T_RP));
        viol_rc  = (rc_cnt < CNT_W'(T_RC));
    end

endmodule

// File: rtl/sdram_device_model.sv
// Two-bank 16-bit SDRAM responder: command decode, storage, CAS-latency pipeline, violation flags.
module sdram_device_model
    import sdram_pkg::*;
#(
    parameter int ROW_W = 2,
    parameter int T_RCD = 2,
    parameter int T_RP  = 2,
    parameter int T_RC  = 6,
    parameter int T_MRD = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdram_cken,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic        sdram_ba,
    input  logic [10:0] sdram_addr,
    input  logic        sdram_ldqm_n,
    input  logic        sdram_hdqm_n,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err,
    output logic [3:0]  err_code,
    output logic [1:0]  mode_cl,
    output logic [15:0] refresh_cnt
);

    localparam int unsigned AW    = 1 + ROW_W + 8;
    localparam int unsigned DEPTH = 2 * (2 ** ROW_W) * 256;

    logic [15:0] mem [DEPTH];

    logic [3:0]  cmd;
    logic        cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr;
    logic [1:0]  do_act, do_pre;
    logic [1:0]  b_active, b_rcd, b_rp, b_rc;
    logic [ROW_W-1:0] b_row [2];
    logic [AW-1:0] mem_addr;
    logic [15:0] rd_word;
    logic        mode_ok, mrd_viol, oe_next;
    logic [15:0] data_next;
    logic [3:0]  code;
    logic [CNT_W-1:0] mrd_cnt;
    logic        s1_v, s2_v;
    logic [15:0] s1_d, s2_d;
    logic        unused_addr;

    assign unused_addr = ^{sdram_addr[9:8], sdram_addr[7:ROW_W], sdram_addr[3]};

    sdram_bank_tracker #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC)) u_bank0 (
        .clk(clk), .reset_n(reset_n), .en(sdram_cken),
        .do_active(do_act[0]), .do_precharge(do_pre[0]), .do_refresh(cmd_ref),
        .row_in(sdram_addr[ROW_W-1:0]), .active(b_active[0]), .row(b_row[0]),
        .viol_rcd(b_rcd[0]), .viol_rp(b_rp[0]), .viol_rc(b_rc[0])
    );

    sdram_bank_tracker #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC)) u_bank1 (
        .clk(clk), .reset_n(reset_n), .en(sdram_cken),
        .do_active(do_act[1]), .do_precharge(do_pre[1]), .do_refresh(cmd_ref),
        .row_in(sdram_addr[ROW_W-1:0]), .active(b_active[1]), .row(b_row[1]),
        .viol_rcd(b_rcd[1]), .viol_rp(b_rp[1]), .viol_rc(b_rc[1])
    );

    // Command decode, per-bank strobes, storage address and pipeline output selection
    always_comb begin
        cmd     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
        cmd_act = sdram_cken && (cmd == CMD_ACTIVE);
        cmd_rd  = sdram_cken && (cmd == CMD_READ);
        cmd_wr  = sdram_cken && (cmd == CMD_WRITE);
        cmd_pre = sdram_cken && (cmd == CMD_PRECHARGE);
        cmd_ref = sdram_cken && (cmd == CMD_REFRESH);
        cmd_lmr = sdram_cken && (cmd == CMD_LOAD_MODE);
        for (int unsigned b = 0; b < 2; b++) begin
            do_act[b] = cmd_act && (sdram_ba == b[0]);
            do_pre[b] = (cmd_pre && (sdram_addr[A10] || sdram_ba == b[0]))
                     || ((cmd_rd || cmd_wr) && sdram_addr[A10] && sdram_ba == b[0]);
        end
        mem_addr = {sdram_ba, b_row[sdram_ba], sdram_addr[7:0]};
        rd_word  = mem[mem_addr];
        mode_ok  = (sdram_addr[MODE_CL_MSB:MODE_CL_LSB] == 3'd2 || sdram_addr[MODE_CL_MSB:MODE_CL_LSB] == 3'd3)
                && (sdram_addr[MODE_BL_MSB:MODE_BL_LSB] == 3'd0);
        // A command inside tMRD sees a mode register that has not settled yet, so it reports as unprogrammed
        mrd_viol = (mrd_cnt < CNT_W'(T_MRD))
                && (cmd_act || cmd_rd || cmd_wr || cmd_pre || cmd_ref || cmd_lmr);
        oe_next   = 1'b0;
        data_next = '0;
        if (mode_cl == 2'd2) begin
            oe_next   = s1_v;
            data_next = s1_d;
        end else if (mode_cl == 2'd3) begin
            oe_next   = s2_v;
            data_next = s2_d;
        end
    end

    // Violation classification for the command being sampled, highest priority first
    always_comb begin
        code = ERR_NONE;
        if (cmd_act) begin
            if (mode_cl == 2'd0 || mrd_viol)  code = ERR_UNPROG;
            else if (b_active[sdram_ba])      code = ERR_ACT_OPEN;
            else if (b_rp[sdram_ba])          code = ERR_TRP;
            else if (b_rc[sdram_ba])          code = ERR_TRC;
        end else if (cmd_rd || cmd_wr) begin
            if (mode_cl == 2'd0 || mrd_viol)  code = ERR_UNPROG;
            else if (!b_active[sdram_ba])     code = ERR_IDLE;
            else if (b_rcd[sdram_ba])         code = ERR_TRCD;
            // Write data would share the bus with read data already launched or about to launch
            else if (cmd_wr && (dq_oe || oe_next)) code = ERR_BUS;
        end else if (cmd_ref) begin
            if (mrd_viol)                     code = ERR_UNPROG;
            else if (|b_active)               code = ERR_ACT_OPEN;
            else if (|b_rp)                   code = ERR_TRP;
            else if (|b_rc)                   code = ERR_TRC;
        end else if (cmd_lmr) begin
            if (mrd_viol)                     code = ERR_UNPROG;
            else if (|b_active)               code = ERR_ACT_OPEN;
            else if (!mode_ok)                code = ERR_MODE;
        end else if (cmd_pre) begin
            if (mrd_viol)                     code = ERR_UNPROG;
        end
    end

    // Byte-wise storage writes; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (reset_n && cmd_wr) begin
            if (!sdram_ldqm_n) mem[mem_addr][7:0]  <= dq_in[7:0];
            if (!sdram_hdqm_n) mem[mem_addr][15:8] <= dq_in[15:8];
        end
    end

    // Mode register, refresh count, read pipeline, and first-error capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
            mode_cl     <= '0;
            refresh_cnt <= '0;
            mrd_cnt     <= '1;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            s1_d        <= '0;
            s2_d        <= '0;
        end else begin
            if (!err && code != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= code;
            end
            if (sdram_cken) begin
                s1_v   <= cmd_rd;
                s1_d   <= rd_word;
                s2_v   <= s1_v;
                s2_d   <= s1_d;
                dq_oe  <= oe_next;
                dq_out <= data_next;
                if (cmd_ref)
                    refresh_cnt <= refresh_cnt + 16'd1;
                if (cmd_lmr) begin
                    mrd_cnt <= CNT_W'(1);
                    if (!(|b_active))
                        mode_cl <= mode_ok ? sdram_addr[MODE_CL_LSB+1:MODE_CL_LSB] : 2'd0;
                end else if (mrd_cnt != '1) begin
                    mrd_cnt <= mrd_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: mode programming, read latency, byte masks, violations.
module tb_sdram_device_model;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sdram_cken = 1'b1;
    logic        sdram_cs_n = 1'b0, sdram_ras_n = 1'b1, sdram_cas_n = 1'b1, sdram_we_n = 1'b1;
    logic        sdram_ba = 1'b0;
    logic [10:0] sdram_addr = '0;
    logic        sdram_ldqm_n = 1'b0, sdram_hdqm_n = 1'b0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        err;
    logic [3:0]  err_code;
    logic [1:0]  mode_cl;
    logic [15:0] refresh_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_device_model #(.ROW_W(2), .T_RCD(2), .T_RP(2), .T_RC(6), .T_MRD(2)) dut (
        .clk(clk), .reset_n(reset_n), .sdram_cken(sdram_cken),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_ldqm_n(sdram_ldqm_n), .sdram_hdqm_n(sdram_hdqm_n), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .err(err), .err_code(err_code),
        .mode_cl(mode_cl), .refresh_cnt(refresh_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one command for one rising edge, then return to NOP 1 time unit after the edge
    task automatic drive(input logic [3:0] c, input logic ba, input logic [10:0] a,
                         input logic lm, input logic hm, input logic [15:0] d);
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
        sdram_ba = ba; sdram_addr = a; sdram_ldqm_n = lm; sdram_hdqm_n = hm; dq_in = d;
        @(posedge clk);
        #1;
        {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = C_NOP;
        sdram_ldqm_n = 1'b0; sdram_hdqm_n = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(C_NOP, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nop(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_dq_oe", 16'(dq_oe), 16'd0);
        check("rst_dq_out", dq_out, 16'h0000);
        check("rst_err", 16'(err), 16'd0);
        check("rst_err_code", 16'(err_code), 16'd0);
        check("rst_mode_cl", 16'(mode_cl), 16'd0);
        check("rst_refresh_cnt", refresh_cnt, 16'd0);

        // CL=2 write then read of the same address
        drive(C_LMR, 1'b0, 11'h020, 1'b0, 1'b0, '0);
        nop(2);
        check("cl2_mode", 16'(mode_cl), 16'd2);
        drive(C_ACT, 1'b0, 11'd5, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_WR, 1'b0, 11'h012, 1'b0, 1'b0, 16'hBEEF);
        drive(C_RD, 1'b0, 11'h012, 1'b0, 1'b0, '0);
        check("cl2_oe_at_n", 16'(dq_oe), 16'd0);
        nop(1);
        check("cl2_oe_at_n1", 16'(dq_oe), 16'd1);
        check("cl2_data", dq_out, 16'hBEEF);
        nop(1);
        check("cl2_oe_at_n2", 16'(dq_oe), 16'd0);
        check("cl2_err", 16'(err), 16'd0);

        // CL=3: data one cycle later
        do_reset();
        drive(C_LMR, 1'b0, 11'h030, 1'b0, 1'b0, '0);
        nop(2);
        check("cl3_mode", 16'(mode_cl), 16'd3);
        drive(C_ACT, 1'b0, 11'd5, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_WR, 1'b0, 11'h012, 1'b0, 1'b0, 16'hCAFE);
        drive(C_RD, 1'b0, 11'h012, 1'b0, 1'b0, '0);
        nop(1);
        check("cl3_oe_at_n1", 16'(dq_oe), 16'd0);
        nop(1);
        check("cl3_oe_at_n2", 16'(dq_oe), 16'd1);
        check("cl3_data", dq_out, 16'hCAFE);
        nop(1);
        check("cl3_oe_at_n3", 16'(dq_oe), 16'd0);
        check("cl3_err", 16'(err), 16'd0);

        // Unsupported CAS latency
        do_reset();
        drive(C_LMR, 1'b0, 11'h040, 1'b0, 1'b0, '0);
        check("badmode_err", 16'(err), 16'd1);
        check("badmode_code", 16'(err_code), 16'd7);
        check("badmode_cl", 16'(mode_cl), 16'd0);

        // Byte masking, then reopen an aliased row after precharge
        do_reset();
        drive(C_LMR, 1'b0, 11'h020, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_ACT, 1'b1, 11'd3, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_WR, 1'b1, 11'h040, 1'b0, 1'b0, 16'hFFFF);
        drive(C_WR, 1'b1, 11'h040, 1'b0, 1'b1, 16'h1234);
        drive(C_RD, 1'b1, 11'h040, 1'b0, 1'b0, '0);
        nop(1);
        check("mask_oe", 16'(dq_oe), 16'd1);
        check("mask_data", dq_out, 16'hFF34);
        drive(C_PRE, 1'b1, 11'h000, 1'b0, 1'b0, '0);
        nop(1);
        drive(C_ACT, 1'b1, 11'd7, 1'b0, 1'b0, '0);
        nop(1);
        drive(C_RD, 1'b1, 11'h040, 1'b0, 1'b0, '0);
        nop(1);
        check("alias_data", dq_out, 16'hFF34);
        check("alias_err", 16'(err), 16'd0);

        // tRCD violation: READ one edge after ACTIVE
        drive(C_ACT, 1'b0, 11'd1, 1'b0, 1'b0, '0);
        drive(C_RD, 1'b0, 11'h000, 1'b0, 1'b0, '0);
        check("trcd_err", 16'(err), 16'd1);
        check("trcd_code", 16'(err_code), 16'd4);

        // READ to an idle bank
        do_reset();
        check("reset_clears_err", 16'(err), 16'd0);
        drive(C_LMR, 1'b0, 11'h020, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_RD, 1'b0, 11'h000, 1'b0, 1'b0, '0);
        check("idle_code", 16'(err_code), 16'd2);

        // REFRESH pair T_RC-1 apart
        do_reset();
        drive(C_REF, 1'b0, 11'h000, 1'b0, 1'b0, '0);
        nop(4);
        drive(C_REF, 1'b0, 11'h000, 1'b0, 1'b0, '0);
        check("trc_short_code", 16'(err_code), 16'd6);
        check("trc_short_cnt", refresh_cnt, 16'd2);

        // REFRESH pair exactly T_RC apart
        do_reset();
        drive(C_REF, 1'b0, 11'h000, 1'b0, 1'b0, '0);
        nop(5);
        drive(C_REF, 1'b0, 11'h000, 1'b0, 1'b0, '0);
        check("trc_ok_err", 16'(err), 16'd0);
        check("trc_ok_cnt", refresh_cnt, 16'd2);

        // WRITE colliding with a pending CL=3 read
        do_reset();
        drive(C_LMR, 1'b0, 11'h030, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_ACT, 1'b0, 11'd2, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_RD, 1'b0, 11'h010, 1'b0, 1'b0, '0);
        nop(1);
        drive(C_WR, 1'b0, 11'h010, 1'b0, 1'b0, 16'h5555);
        check("bus_code", 16'(err_code), 16'd8);

        // Reset while a CL=2 read is in flight
        do_reset();
        drive(C_LMR, 1'b0, 11'h020, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_ACT, 1'b0, 11'd2, 1'b0, 1'b0, '0);
        nop(2);
        drive(C_RD, 1'b0, 11'h010, 1'b0, 1'b0, '0);
        reset_n = 1'b0;
        nop(1);
        reset_n = 1'b1;
        check("flush_oe", 16'(dq_oe), 16'd0);
        check("flush_err", 16'(err), 16'd0);
        nop(1);
        check("flush_oe_later", 16'(dq_oe), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
